// File: rtl/text_fetch_pkg.sv
// ==== text_fetch_pkg : shared defaults, widths and FSM encoding for text_fetch_ctrl ====
// Rev 1.0
`default_nettype none

package text_fetch_pkg;

  localparam int unsigned c_COLS    = 40;
  localparam int unsigned c_GLYPH_W = 16;
  localparam int unsigned c_GLYPH_H = 32;
  localparam int unsigned c_LINES   = 480;

  localparam int unsigned c_CHAR_AW = 13;
  localparam int unsigned c_FONT_AW = 7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_C_ADDR = 3'd1,
    S_C_CAP  = 3'd2,
    S_F_ADDR = 3'd3,
    S_F_CAP  = 3'd4,
    S_OUT    = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/glyph_row_mux.sv
// ==== glyph_row_mux : picks one glyph row out of a font word, optional inverse video ====
// Rev 1.0
`default_nettype none

module glyph_row_mux #(
  parameter int unsigned WORD_W  = 512,
  parameter int unsigned GLYPH_W = 16,
  parameter int unsigned ROW_W   = 5
) (
  input  logic [WORD_W-1:0]  word_i,
  input  logic [ROW_W-1:0]   row_i,
  input  logic               invert_i,
  output logic [GLYPH_W-1:0] row_o
);

  localparam int unsigned c_IDX_W = $clog2(WORD_W);

  logic [c_IDX_W-1:0] w_base;
  logic [GLYPH_W-1:0] w_slice;

  assign w_base  = c_IDX_W'(row_i) * c_IDX_W'(GLYPH_W);
  assign w_slice = word_i[w_base +: GLYPH_W];
  assign row_o   = invert_i ? ~w_slice : w_slice;

endmodule

`default_nettype wire

// File: rtl/text_fetch_ctrl.sv
// ==== text_fetch_ctrl : fetches char codes and glyph rows for one pixel line of text ====
// Rev 1.0
`default_nettype none

module text_fetch_ctrl
  import text_fetch_pkg::*;
#(
  parameter int unsigned COLS    = c_COLS,
  parameter int unsigned GLYPH_W = c_GLYPH_W,
  parameter int unsigned GLYPH_H = c_GLYPH_H,
  parameter int unsigned LINES   = c_LINES
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic                 line_start,
  input  logic [8:0]           line_idx,
  input  logic [c_CHAR_AW-1:0] base_addr,
  output logic                 busy,
  output logic                 line_done,
  output logic                 line_err,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [GLYPH_W-1:0]   pix_data,
  output logic                 pix_last,
  output logic [c_CHAR_AW-1:0] char_mem_p2_address,
  output logic                 char_mem_p2_chipselect,
  output logic                 char_mem_p2_clken,
  input  logic [7:0]           char_mem_p2_readdata,
  output logic                 char_mem_p2_write,
  output logic [7:0]           char_mem_p2_writedata,
  output logic [c_FONT_AW-1:0] font_mem_p_address,
  output logic                 font_mem_p_chipselect,
  output logic                 font_mem_p_clken,
  input  logic [511:0]         font_mem_p_readdata,
  output logic                 font_mem_p_write,
  output logic                 font_mem_p_debugaccess,
  output logic [511:0]         font_mem_p_writedata,
  output logic [63:0]          font_mem_p_byteenable
);

  localparam int unsigned c_COL_W = $clog2(COLS);
  localparam int unsigned c_ROW_W = $clog2(GLYPH_H);
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(COLS - 1);

  state_e                 state_q, state_d;
  logic [8:0]             line_q;
  logic [c_CHAR_AW-1:0]   base_q;
  logic [c_COL_W-1:0]     col_q;
  logic [7:0]             code_q;
  logic [GLYPH_W-1:0]     row_q;
  logic                   done_q;
  logic                   err_q;

  logic                   w_accept;
  logic                   w_col_last;
  logic [c_CHAR_AW-1:0]   w_char_addr;
  logic [GLYPH_W-1:0]     w_row;

  assign w_accept   = line_start && (32'(line_idx) < LINES);
  assign w_col_last = (col_q == c_COL_LAST);
  // Text row = pixel line / glyph height; scroll base wraps around char_mem.
  assign w_char_addr = base_q
                     + c_CHAR_AW'(line_q >> c_ROW_W) * c_CHAR_AW'(COLS)
                     + c_CHAR_AW'(col_q);

  glyph_row_mux #(
    .WORD_W  (512),
    .GLYPH_W (GLYPH_W),
    .ROW_W   (c_ROW_W)
  ) u_glyph_row_mux (
    .word_i   (font_mem_p_readdata),
    .row_i    (line_q[c_ROW_W-1:0]),
    .invert_i (code_q[7]),
    .row_o    (w_row)
  );

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (w_accept) state_d = S_C_ADDR;
      S_C_ADDR: state_d = S_C_CAP;
      S_C_CAP:  state_d = S_F_ADDR;
      S_F_ADDR: state_d = S_F_CAP;
      S_F_CAP:  state_d = S_OUT;
      S_OUT:    if (pix_ready) state_d = w_col_last ? S_IDLE : S_C_ADDR;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      line_q <= '0;
      base_q <= '0;
      col_q  <= '0;
      code_q <= '0;
      row_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            line_q <= line_idx;
            base_q <= base_addr;
            col_q  <= '0;
          end else if (line_start) begin
            err_q <= 1'b1;
          end
        end
        S_C_CAP: code_q <= char_mem_p2_readdata;
        S_F_CAP: row_q  <= w_row;
        S_OUT: begin
          if (pix_ready) begin
            if (w_col_last) done_q <= 1'b1;
            else            col_q  <= col_q + c_COL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy                   = (state_q != S_IDLE);
    char_mem_p2_chipselect = (state_q == S_C_ADDR);
    char_mem_p2_address    = char_mem_p2_chipselect ? w_char_addr : '0;
    char_mem_p2_clken      = busy;
    font_mem_p_chipselect  = (state_q == S_F_ADDR);
    font_mem_p_address     = font_mem_p_chipselect ? code_q[c_FONT_AW-1:0] : '0;
    font_mem_p_clken       = busy;
    pix_valid              = (state_q == S_OUT);
    pix_last               = pix_valid && w_col_last;
    pix_data               = row_q;
  end

  assign line_done              = done_q;
  assign line_err               = err_q;
  assign char_mem_p2_write      = 1'b0;
  assign char_mem_p2_writedata  = '0;
  assign font_mem_p_write       = 1'b0;
  assign font_mem_p_debugaccess = 1'b0;
  assign font_mem_p_writedata   = '0;
  assign font_mem_p_byteenable  = '1;

endmodule

`default_nettype wire

// File: tb/tb_text_fetch_ctrl.sv
// ==== tb_text_fetch_ctrl : scoreboard bench for text_fetch_ctrl ====
// Rev 1.0
`default_nettype none

module tb_text_fetch_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         line_start = 1'b0;
  logic [8:0]   line_idx = '0;
  logic [12:0]  base_addr = '0;
  logic         busy, line_done, line_err, pix_valid, pix_last;
  logic         pix_ready = 1'b1;
  logic [15:0]  pix_data;
  logic [12:0]  char_addr;
  logic         char_cs, char_clken, char_wr;
  logic [7:0]   char_rd = '0;
  logic [7:0]   char_wd;
  logic [6:0]   font_addr;
  logic         font_cs, font_clken, font_wr, font_dbg;
  logic [511:0] font_rd = '0;
  logic [511:0] font_wd;
  logic [63:0]  font_be;

  text_fetch_ctrl dut (
    .clk_clk                (clk),
    .reset_reset            (rst),
    .line_start             (line_start),
    .line_idx               (line_idx),
    .base_addr              (base_addr),
    .busy                   (busy),
    .line_done              (line_done),
    .line_err               (line_err),
    .pix_valid              (pix_valid),
    .pix_ready              (pix_ready),
    .pix_data               (pix_data),
    .pix_last               (pix_last),
    .char_mem_p2_address    (char_addr),
    .char_mem_p2_chipselect (char_cs),
    .char_mem_p2_clken      (char_clken),
    .char_mem_p2_readdata   (char_rd),
    .char_mem_p2_write      (char_wr),
    .char_mem_p2_writedata  (char_wd),
    .font_mem_p_address     (font_addr),
    .font_mem_p_chipselect  (font_cs),
    .font_mem_p_clken       (font_clken),
    .font_mem_p_readdata    (font_rd),
    .font_mem_p_write       (font_wr),
    .font_mem_p_debugaccess (font_dbg),
    .font_mem_p_writedata   (font_wd),
    .font_mem_p_byteenable  (font_be)
  );

  always #5 clk = ~clk;

  logic [7:0]   char_mem [8192];
  logic [511:0] font_mem [128];

  // One-cycle read latency memories.
  always @(posedge clk) begin
    if (char_cs && char_clken) char_rd <= char_mem[char_addr];
    if (font_cs && font_clken) font_rd <= font_mem[font_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [12:0] exp_addr [$];
  logic [15:0] exp_data [$];
  logic        exp_last [$];
  logic [12:0] addr_log [$];
  logic [15:0] data_log [$];
  int words_seen = 0, last_seen = 0, done_cnt = 0, err_cnt = 0;

  always @(negedge clk) begin
    #1;
    if (char_cs) begin
      addr_log.push_back(char_addr);
      vectors++;
      if (exp_addr.size() == 0) begin
        miscompares++;
        $display("FAIL char_addr: unexpected access at %h, none required", char_addr);
      end else begin
        logic [12:0] a;
        a = exp_addr.pop_front();
        if (char_addr !== a) begin
          miscompares++;
          $display("FAIL char_addr: got %h required %h", char_addr, a);
        end
      end
    end
    if (pix_valid && pix_ready) begin
      data_log.push_back(pix_data);
      words_seen++;
      if (pix_last) last_seen++;
      vectors++;
      if (exp_data.size() == 0) begin
        miscompares++;
        $display("FAIL pix_word: unexpected word %h, none required", pix_data);
      end else begin
        logic [15:0] d;
        logic        l;
        d = exp_data.pop_front();
        l = exp_last.pop_front();
        if ({pix_data, pix_last} !== {d, l}) begin
          miscompares++;
          $display("FAIL pix_word: got data=%h last=%b required data=%h last=%b",
                   pix_data, pix_last, d, l);
        end
      end
    end
    if (line_done) done_cnt++;
    if (line_err)  err_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    addr_log.delete();
    data_log.delete();
    words_seen = 0;
    last_seen  = 0;
  endtask

  // Drives a one-cycle request; cycle N is the one whose closing edge samples it.
  task automatic start_line(input int idx, input logic [12:0] base, input bit push, output int t0);
    @(negedge clk);
    line_idx   = 9'(idx);
    base_addr  = base;
    line_start = 1'b1;
    t0 = cyc;
    if (push) begin
      for (int c = 0; c < 40; c++) begin
        logic [12:0] a;
        logic [7:0]  code;
        logic [15:0] s;
        a    = base + 13'((idx / 32) * 40) + 13'(c);
        code = char_mem[a];
        s    = font_mem[code[6:0]][(idx % 32) * 16 +: 16];
        if (code[7]) s = ~s;
        exp_addr.push_back(a);
        exp_data.push_back(s);
        exp_last.push_back(c == 39);
      end
    end
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_line_end(input int t0, input int budget, output int first_k, output int done_k);
    first_k = -1;
    done_k  = -1;
    while ((cyc - t0) <= budget && done_k < 0) begin
      if (pix_valid && first_k < 0) first_k = cyc - t0;
      if (line_done) done_k = cyc - t0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [54:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    v = {line_done, line_err, pix_valid, pix_last, pix_data, char_addr, char_cs, char_clken,
         char_wr, char_wd, font_addr, font_cs, font_clken, font_wr, font_dbg};
    vectors++;
    if (v !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h required 0", v);
    end
    vectors++;
    if (font_wd !== '0) begin
      miscompares++;
      $display("FAIL reset_font_wd: got nonzero required 0");
    end
    vectors++;
    if (font_be !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      miscompares++;
      $display("FAIL reset_byteenable: got %h required ffffffffffffffff", font_be);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b required 0", busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int t0, first_k, done_k, d0;
    char_mem[0] = 8'h41;
    font_mem[7'h41][15:0] = 16'h1234;
    clear_logs();
    d0 = done_cnt;
    start_line(0, 13'h0000, 1'b1, t0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy: got %b required 1", busy);
    end
    wait_line_end(t0, 300, first_k, done_k);
    repeat (3) @(negedge clk);
    vectors++;
    if (first_k !== 5) begin
      miscompares++;
      $display("FAIL basic_first_valid: got N+%0d required N+5", first_k);
    end
    vectors++;
    if (((data_log.size() > 0) ? data_log[0] : 16'hxxxx) !== 16'h1234) begin
      miscompares++;
      $display("FAIL basic_first_data: got %h required 1234",
               (data_log.size() > 0) ? data_log[0] : 16'hxxxx);
    end
    vectors++;
    if (words_seen !== 40 || last_seen !== 1) begin
      miscompares++;
      $display("FAIL basic_count: got %0d words %0d last required 40 words 1 last",
               words_seen, last_seen);
    end
    vectors++;
    if (done_k !== 201 || (done_cnt - d0) !== 1) begin
      miscompares++;
      $display("FAIL basic_done: got N+%0d x%0d required N+201 x1", done_k, done_cnt - d0);
    end
    vectors++;
    if (busy !== 1'b0 || exp_data.size() !== 0) begin
      miscompares++;
      $display("FAIL basic_end: got busy=%b pending=%0d required busy=0 pending=0",
               busy, exp_data.size());
    end
  endtask

  task automatic test_inverse();
    int t0, first_k, done_k;
    char_mem[0] = 8'hC1;
    clear_logs();
    start_line(0, 13'h0000, 1'b1, t0);
    wait_line_end(t0, 300, first_k, done_k);
    vectors++;
    if (((data_log.size() > 0) ? data_log[0] : 16'hxxxx) !== 16'hEDCB) begin
      miscompares++;
      $display("FAIL inverse_data: got %h required edcb",
               (data_log.size() > 0) ? data_log[0] : 16'hxxxx);
    end
    char_mem[40] = 8'h05;
    font_mem[5][95:80] = 16'hBEEF;
    clear_logs();
    start_line(37, 13'h0000, 1'b1, t0);
    wait_line_end(t0, 300, first_k, done_k);
    vectors++;
    if (addr_log.size() !== 40 || addr_log[0] !== 13'd40 || addr_log[39] !== 13'd79) begin
      miscompares++;
      $display("FAIL row37_addr: got n=%0d first=%0d required n=40 first=40 last=79",
               addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : 13'h0);
    end
    vectors++;
    if (((data_log.size() > 0) ? data_log[0] : 16'hxxxx) !== 16'hBEEF || done_k !== 201) begin
      miscompares++;
      $display("FAIL row37_slice: got %h done N+%0d required beef done N+201",
               (data_log.size() > 0) ? data_log[0] : 16'hxxxx, done_k);
    end
  endtask

  task automatic test_wrap();
    int t0, first_k, done_k;
    clear_logs();
    start_line(0, 13'h1FF0, 1'b1, t0);
    wait_line_end(t0, 300, first_k, done_k);
    vectors++;
    if (addr_log.size() !== 40 || addr_log[0] !== 13'h1FF0 || addr_log[20] !== 13'h0004) begin
      miscompares++;
      $display("FAIL wrap_addr: got n=%0d col20=%h required n=40 col0=1ff0 col20=0004",
               addr_log.size(), (addr_log.size() > 20) ? addr_log[20] : 13'h0);
    end
  endtask

  task automatic test_stall();
    int t0, done_k, stalls, d0, e0;
    logic [15:0] held;
    clear_logs();
    d0 = done_cnt;
    e0 = err_cnt;
    stalls = 0;
    held = '0;
    done_k = -1;
    start_line(0, 13'h0000, 1'b1, t0);
    while ((cyc - t0) <= 400 && done_k < 0) begin
      if (line_done) done_k = cyc - t0;
      if (pix_valid && words_seen == 5 && stalls < 3) begin
        pix_ready  = 1'b0;
        line_idx   = 9'd100;
        line_start = (stalls == 1);
        if (stalls == 0) held = pix_data;
        else begin
          vectors++;
          if (pix_data !== held || pix_last !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold: got %h required %h", pix_data, held);
          end
        end
        vectors++;
        if (char_cs !== 1'b0 || font_cs !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_cs: got char=%b font=%b required 0 0", char_cs, font_cs);
        end
        stalls++;
      end else begin
        pix_ready  = 1'b1;
        line_start = 1'b0;
      end
      @(negedge clk);
    end
    pix_ready  = 1'b1;
    line_start = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (done_k !== 204 || (done_cnt - d0) !== 1 || words_seen !== 40) begin
      miscompares++;
      $display("FAIL stall_done: got N+%0d x%0d words=%0d required N+204 x1 words=40",
               done_k, done_cnt - d0, words_seen);
    end
    vectors++;
    if ((err_cnt - e0) !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_ignore: got err=%0d busy=%b required err=0 busy=0", err_cnt - e0, busy);
    end
  endtask

  task automatic test_err();
    int t0, e0, busy_seen;
    e0 = err_cnt;
    busy_seen = 0;
    start_line(480, 13'h0000, 1'b0, t0);
    vectors++;
    if (line_err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL err_pulse: got err=%b busy=%b required err=1 busy=0", line_err, busy);
    end
    repeat (10) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    vectors++;
    if ((err_cnt - e0) !== 1 || busy_seen !== 0) begin
      miscompares++;
      $display("FAIL err_single: got pulses=%0d busy_cycles=%0d required 1 0",
               err_cnt - e0, busy_seen);
    end
  endtask

  task automatic test_reset_midline();
    int t0, first_k, done_k, d0, e0;
    clear_logs();
    start_line(0, 13'h0000, 1'b1, t0);
    while (words_seen < 12 && (cyc - t0) < 300) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, pix_valid, char_cs, char_clken, font_cs, font_clken, line_done, line_err} !== 8'h00
        || pix_data !== 16'h0 || font_be !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      miscompares++;
      $display("FAIL async_reset: got busy=%b valid=%b cs=%b%b data=%h required all 0",
               busy, pix_valid, char_cs, font_cs, pix_data);
    end
    exp_addr.delete();
    exp_data.delete();
    exp_last.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;
    repeat (10) @(negedge clk);
    vectors++;
    if ((done_cnt - d0) !== 0 || (err_cnt - e0) !== 0) begin
      miscompares++;
      $display("FAIL reset_stray: got done=%0d err=%0d required 0 0", done_cnt - d0, err_cnt - e0);
    end
    clear_logs();
    start_line(0, 13'h0000, 1'b1, t0);
    wait_line_end(t0, 300, first_k, done_k);
    vectors++;
    if (((addr_log.size() > 0) ? addr_log[0] : 13'h1FFF) !== 13'h0000 || first_k !== 5
        || done_k !== 201 || words_seen !== 40) begin
      miscompares++;
      $display("FAIL reset_restart: got first=N+%0d done=N+%0d words=%0d required N+5 N+201 40",
               first_k, done_k, words_seen);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) char_mem[i] = 8'($urandom);
    for (int i = 0; i < 128; i++)
      for (int j = 0; j < 16; j++) font_mem[i][j*32 +: 32] = $urandom;
    test_reset();
    test_basic();
    test_inverse();
    test_wrap();
    test_stall();
    test_err();
    test_reset_midline();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
